// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : shares one memory bus between instruction fetch and data access
// Rev 1.0
// ============================================================================
module bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_req_o
);

  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic [3:0]  starve_q;
  logic        owner_data_q;
  logic        data_win;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  assign data_win    = d_req_i & (~if_req_i | (starve_q < STARVE_LIM));
  assign stall_req_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      starve_q     <= '0;
      owner_data_q <= 1'b0;
      if_rdata_o   <= '0;
      if_ack_o     <= 1'b0;
      d_rdata_o    <= '0;
      d_ack_o      <= 1'b0;
      bus_ce_o     <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_sel_o    <= '0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_win) begin
            owner_data_q <= 1'b1;
            bus_ce_o     <= 1'b1;
            bus_we_o     <= d_we_i;
            bus_sel_o    <= d_sel_i;
            bus_addr_o   <= d_addr_i;
            bus_wdata_o  <= d_wdata_i;
            wcnt_q       <= WAIT_LAST;
            state_q      <= BUSY;
            if (!if_req_i)
              starve_q <= '0;
            else if (starve_q != STARVE_LIM)
              starve_q <= starve_q + 4'd1;
          end else if (if_req_i) begin
            owner_data_q <= 1'b0;
            bus_ce_o     <= 1'b1;
            bus_we_o     <= 1'b0;
            bus_sel_o    <= 4'b1111;
            bus_addr_o   <= if_addr_i;
            bus_wdata_o  <= '0;
            wcnt_q       <= WAIT_LAST;
            starve_q     <= '0;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else begin
            if (owner_data_q) begin
              d_ack_o <= 1'b1;
              if (!bus_we_o)
                d_rdata_o <= bus_rdata_i;
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= bus_rdata_i;
            end
            bus_ce_o  <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= '0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if_ack_o <= 1'b0;
          d_ack_o  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
